stream_demux_1_4: RTL and testbench

//   1-to-4 demultiplexer for a valid/ready stream: the distribution-side

---
 rtl/stream_demux_1_4.sv | 64 ++++++
 tb/tb_stream_demux_1_4.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/stream_demux_1_4.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_1_4
// Purpose  : 1-to-4 valid/ready stream demux with a one-entry register and a
//            wrapping delivered-word counter on each lane.
// Revision : 1.0 - initial release
// ============================================================================
module stream_demux_1_4 #(
  parameter int W  = 2,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic [1:0]      in_sel,
  output logic [3:0]      out_valid,
  input  logic [3:0]      out_ready,
  output logic [4*W-1:0]  out_data,
  output logic [4*CW-1:0] out_cnt
);

  logic [3:0] r_full;
  logic       w_accept;

  // Acceptance looks only at the addressed lane; a stalled neighbour never blocks it.
  assign in_ready  = !r_full[in_sel] | out_ready[in_sel];
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_full;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic          w_load;
      logic          w_drain;
      logic [W-1:0]  r_data;
      logic [CW-1:0] r_cnt;

      assign w_load  = w_accept && (in_sel == 2'(gi));
      assign w_drain = r_full[gi] & out_ready[gi];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_full[gi] <= 1'b0;
          r_data     <= '0;
          r_cnt      <= '0;
        end else begin
          // Load-and-drain in the same edge keeps the lane full with no bubble.
          r_full[gi] <= w_load | (r_full[gi] & !w_drain);
          if (w_load)
            r_data <= in_data;
          if (w_drain)
            r_cnt <= r_cnt + 1'b1;
        end
      end

      assign out_data[gi*W +: W]  = r_data;
      assign out_cnt[gi*CW +: CW] = r_cnt;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_1_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_demux_1_4
// Purpose  : Table-driven bench for stream_demux_1_4 plus reset/wrap sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1_4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  out_data;
  logic [31:0] out_cnt;

  int checks = 0;
  int errors = 0;

  stream_demux_1_4 #(.W(2), .CW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic [1:0]  data;
    logic [3:0]  ordy;
    logic        erdy;
    logic [3:0]  eov;
    logic [7:0]  eod;
    logic [31:0] ecnt;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [1:0] sel, input logic [1:0] data,
                       input logic [3:0] ordy);
    @(negedge clk);
    in_valid  = iv;
    in_sel    = sel;
    in_data   = data;
    out_ready = ordy;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // lane order in packed fields is {l3,l2,l1,l0}
    tbl[0]  = '{1'b1, 2'd2, 2'b11, 4'b0000, 1'b1, 4'b0100, 8'b00_11_00_00, 32'h00000000};
    tbl[1]  = '{1'b1, 2'd1, 2'b10, 4'b0000, 1'b1, 4'b0110, 8'b00_11_10_00, 32'h00000000};
    tbl[2]  = '{1'b1, 2'd1, 2'b01, 4'b0000, 1'b0, 4'b0110, 8'b00_11_10_00, 32'h00000000};
    tbl[3]  = '{1'b1, 2'd3, 2'b01, 4'b0000, 1'b1, 4'b1110, 8'b01_11_10_00, 32'h00000000};
    tbl[4]  = '{1'b1, 2'd0, 2'b10, 4'b0000, 1'b1, 4'b1111, 8'b01_11_10_10, 32'h00000000};
    tbl[5]  = '{1'b1, 2'd0, 2'b00, 4'b0001, 1'b1, 4'b1111, 8'b01_11_10_00, 32'h00000001};
    tbl[6]  = '{1'b1, 2'd0, 2'b01, 4'b0001, 1'b1, 4'b1111, 8'b01_11_10_01, 32'h00000002};
    tbl[7]  = '{1'b1, 2'd0, 2'b10, 4'b0001, 1'b1, 4'b1111, 8'b01_11_10_10, 32'h00000003};
    tbl[8]  = '{1'b1, 2'd0, 2'b11, 4'b0001, 1'b1, 4'b1111, 8'b01_11_10_11, 32'h00000004};
    tbl[9]  = '{1'b0, 2'd0, 2'b00, 4'b1010, 1'b0, 4'b0101, 8'b01_11_10_11, 32'h01000104};
    tbl[10] = '{1'b0, 2'd0, 2'b00, 4'b0101, 1'b1, 4'b0000, 8'b01_11_10_11, 32'h01010105};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = 2'd0;
    out_ready = 4'b0000;
    #12;
    chk("reset_out_valid", {28'd0, out_valid}, 32'h0);
    chk("reset_out_data",  {24'd0, out_data},  32'h0);
    chk("reset_out_cnt",   out_cnt,            32'h0);
    chk("reset_in_ready",  {31'd0, in_ready},  32'h1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].iv, tbl[i].sel, tbl[i].data, tbl[i].ordy);
      chk($sformatf("v%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, tbl[i].erdy});
      step();
      chk($sformatf("v%0d_out_valid", i), {28'd0, out_valid}, {28'd0, tbl[i].eov});
      chk($sformatf("v%0d_out_data", i),  {24'd0, out_data},  {24'd0, tbl[i].eod});
      chk($sformatf("v%0d_out_cnt", i),   out_cnt,            tbl[i].ecnt);
    end

    // Fill all four lanes, then pulse reset between edges.
    for (int l = 0; l < 4; l++) begin
      drive(1'b1, 2'(l), 2'(l), 4'b0000);
      step();
    end
    chk("fill_out_valid", {28'd0, out_valid}, 32'hF);
    chk("fill_out_data",  {24'd0, out_data},  {24'd0, 8'b11_10_01_00});
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("async_rst_out_valid", {28'd0, out_valid}, 32'h0);
    chk("async_rst_out_cnt",   out_cnt,            32'h0);
    chk("async_rst_out_data",  {24'd0, out_data},  32'h0);
    #2;
    reset = 1'b0;
    step();
    chk("post_rst_no_replay", {28'd0, out_valid}, 32'h0);

    drive(1'b1, 2'd2, 2'b11, 4'b0000);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'h1);
    step();
    chk("post_rst_out_valid", {28'd0, out_valid}, 32'h4);
    chk("post_rst_out_data",  {24'd0, out_data},  {24'd0, 8'b00_11_00_00});
    chk("post_rst_out_cnt",   out_cnt,            32'h0);

    // 256 words streamed into lane 3 with its consumer always ready.
    for (int k = 0; k < 256; k++) begin
      drive(1'b1, 2'd3, 2'(k), 4'b1000);
      chk($sformatf("wrap_in_ready_%0d", k), {31'd0, in_ready}, 32'h1);
      step();
      chk($sformatf("wrap_data_%0d", k), {30'd0, out_data[7:6]}, {30'd0, 2'(k)});
    end
    chk("wrap_cnt_255", out_cnt, 32'hFF000000);
    drive(1'b0, 2'd3, 2'd0, 4'b1000);
    step();
    chk("wrap_cnt_0",     out_cnt,            32'h0);
    chk("wrap_out_valid", {28'd0, out_valid}, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
